ysyx_22040750_pc_fetch: RTL
===========================

Name: ysyx_22040750_pc_fetch

Overview:
- Consumer end of the dnpc valid/ready interface. Owns the architectural PC register and accepts redirect/next PC values from the next-PC generator.
- Issues instruction reads on a 64-bit read-address/read-data handshake bus.
- Presents fetched instructions to the IF/ID boundary with valid/ready.
- Also returns snpc (PC+4) to the next-PC generator.

Parameters:
- RESET_PC, 32'h8000_0000, PC value fetched first after reset
- ADDR_W, 32, PC/address width

Ports:
- I_clk  in  1  clock
- I_rst_n  in  1  reset, asynchronous, active-low
- I_dnpc  in  32  next PC from the next-PC generator
- I_dnpc_valid  in  1  I_dnpc valid
- O_dnpc_ready  out  1  block can accept a new PC
- I_flush  in  1  kill the in-flight/held instruction (redirect pending)
- O_araddr  out  32  instruction fetch address, 8-byte aligned
- O_arvalid  out  1  fetch request valid
- I_arready  in  1  memory accepts request
- I_rdata  in  64  read data
- I_rresp  in  2  read response; nonzero = error
- I_rvalid  in  1  read data valid
- O_rready  out  1  block accepts read data
- O_IF_ID_valid  out  1  instruction valid toward decode
- I_IF_ID_ready  in  1  decode accepts instruction
- O_IF_ID_pc  out  32  PC of presented instruction
- O_IF_ID_inst  out  32  presented instruction
- O_IF_ID_err  out  1  fetch access fault for presented instruction
- O_snpc  out  32  O_IF_ID_pc + 4

Behaviour:
- State machine. States: REQ, WAIT, HOLD, IDLE. One fetch is outstanding at most.
- Async reset (I_rst_n=0): state=REQ, pc=RESET_PC, drop=0. All valid outputs are 0 except O_arvalid=1 after release. O_IF_ID_pc=RESET_PC, O_IF_ID_inst=0, O_IF_ID_err=0. Reset mid-transaction abandons it; the bench holds the memory model in reset too.
- REQ: O_arvalid=1, O_araddr={pc[31:3],3'b0}. On I_arready, go to WAIT.
- WAIT: O_rready=1. On I_rvalid:
  - If drop=1: discard the data, clear drop, go to IDLE.
  - Otherwise latch inst = pc[2] ? I_rdata[63:32] : I_rdata[31:0], set err=(I_rresp!=0), and go to HOLD.
- HOLD: O_IF_ID_valid=1; inst, pc and err are held stable until I_IF_ID_ready.
- IDLE: no request outstanding; waiting for a new PC.
- O_dnpc_ready = (state==IDLE) | (state==HOLD & (I_IF_ID_ready | I_flush)).
- dnpc handshake (I_dnpc_valid & O_dnpc_ready): pc<=I_dnpc, go to REQ next cycle. Latency from accept to O_arvalid is 1 cycle. A HOLD->IDLE exit with no dnpc handshake in the same cycle goes to IDLE.
- I_IF_ID_ready with no dnpc in HOLD: go to IDLE; O_IF_ID_valid falls the next cycle.
- Flush:
  - In HOLD: O_IF_ID_valid is forced to 0 in that cycle (combinational mask); the instruction is dropped.
  - In WAIT: set drop=1.
  - In REQ: the request completes normally, but drop=1 is set so its data is discarded.
  - In IDLE: no effect.
- Flush together with a dnpc handshake in HOLD: the new PC is accepted, the old instruction is dropped.
- A flush arriving in WAIT in the same cycle as I_rvalid discards that data.
- O_dnpc_ready=0 in REQ and WAIT. A redirect arriving then waits upstream (the generator holds dnpc).
- O_snpc = O_IF_ID_pc + 4, 32-bit wrap: 32'hFFFF_FFFC -> 0.
- Misalignment: pc[1:0]!=0 is not checked here; the bits are passed through in O_IF_ID_pc.
- Throughput: one instruction per 3 cycles minimum (REQ, WAIT, HOLD) with zero-wait memory.

Decomposition:
- Shared package: state encoding localparams (REQ/WAIT/HOLD/IDLE), RESET_PC default, response code OKAY=2'b00.
- One natural sub-module: ysyx_22040750_word_sel, which selects the 32-bit half of the 64-bit rdata by pc[2]. Everything else lives in one module.

Test Plan:
- Reset release, memory returns 64'h0000_0013_0010_0093 with zero wait -> O_araddr=32'h8000_0000; O_IF_ID_inst=32'h0010_0093, pc=32'h8000_0000; O_snpc=32'h8000_0004.
- In HOLD, drive I_dnpc=32'h8000_0004 valid with I_IF_ID_ready=1 -> handshake completes the same cycle. Next cycle O_araddr=32'h8000_0000 and the upper word 32'h0000_0013 is presented.
- Decode stalls (I_IF_ID_ready=0) for 5 cycles -> O_IF_ID_valid stays 1 with pc/inst stable; O_dnpc_ready=0 throughout.
- Flush in WAIT, then I_rvalid with 32'hDEAD_BEEF -> no O_IF_ID_valid pulse; state goes to IDLE. A dnpc of 32'h8000_0100 is then fetched from O_araddr=32'h8000_0100.
- I_rresp=2'b10 on fetch of 32'h8000_0008 -> O_IF_ID_err=1 with O_IF_ID_pc=32'h8000_0008; err clears on the next good fetch.
- Assert I_rst_n=0 while in WAIT -> outputs return asynchronously to reset values, and the first request after release is to 32'h8000_0000.

Source files
------------

// File: rtl/ysyx_22040750_pc_fetch_pkg.sv
// rtl/ysyx_22040750_pc_fetch_pkg.sv - shared types and constants for the PC/fetch stage
package ysyx_22040750_pc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_IDLE = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

endpackage

// File: rtl/ysyx_22040750_pc_fetch_if.sv
// rtl/ysyx_22040750_pc_fetch_if.sv - instruction read-address/read-data bus
interface ysyx_22040750_pc_fetch_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] O_araddr;
    logic              O_arvalid;
    logic              I_arready;
    logic [63:0]       I_rdata;
    logic [1:0]        I_rresp;
    logic              I_rvalid;
    logic              O_rready;

    modport master (
        output O_araddr, O_arvalid, O_rready,
        input  I_arready, I_rdata, I_rresp, I_rvalid
    );

    modport slave (
        input  O_araddr, O_arvalid, O_rready,
        output I_arready, I_rdata, I_rresp, I_rvalid
    );
endinterface

// File: rtl/ysyx_22040750_word_sel.sv
// rtl/ysyx_22040750_word_sel.sv - pick the 32-bit instruction out of a 64-bit beat
module ysyx_22040750_word_sel (
    input  logic        I_sel_hi,
    input  logic [63:0] I_rdata,
    output logic [31:0] O_word
);
    assign O_word = I_sel_hi ? I_rdata[63:32] : I_rdata[31:0];
endmodule

// File: rtl/ysyx_22040750_pc_fetch.sv
// rtl/ysyx_22040750_pc_fetch.sv - PC register and single-outstanding instruction fetch
module ysyx_22040750_pc_fetch
    import ysyx_22040750_pc_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic [ADDR_W-1:0] I_dnpc,
    input  logic              I_dnpc_valid,
    output logic              O_dnpc_ready,
    input  logic              I_flush,
    output logic              O_IF_ID_valid,
    input  logic              I_IF_ID_ready,
    output logic [ADDR_W-1:0] O_IF_ID_pc,
    output logic [31:0]       O_IF_ID_inst,
    output logic              O_IF_ID_err,
    output logic [ADDR_W-1:0] O_snpc,
    ysyx_22040750_pc_fetch_if.master bus
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic              err_q, err_d;
    logic              drop_q, drop_d;
    logic [31:0]       sel_word;
    logic              dnpc_fire;

    ysyx_22040750_word_sel u_word_sel (
        .I_sel_hi (pc_q[2]),
        .I_rdata  (bus.I_rdata),
        .O_word   (sel_word)
    );

    assign bus.O_arvalid = (state_q == ST_REQ);
    assign bus.O_araddr  = {pc_q[ADDR_W-1:3], 3'b000};
    assign bus.O_rready  = (state_q == ST_WAIT);

    // Flush masks the held instruction combinationally so decode never sees it.
    assign O_IF_ID_valid = (state_q == ST_HOLD) & ~I_flush;
    assign O_dnpc_ready  = (state_q == ST_IDLE) |
                           ((state_q == ST_HOLD) & (I_IF_ID_ready | I_flush));
    assign dnpc_fire     = I_dnpc_valid & O_dnpc_ready;

    assign O_IF_ID_pc   = pc_q;
    assign O_IF_ID_inst = inst_q;
    assign O_IF_ID_err  = err_q;
    assign O_snpc       = pc_q + ADDR_W'(4);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        err_d   = err_q;
        drop_d  = drop_q;
        case (state_q)
            ST_REQ: begin
                // The request still goes out; its data is marked for discard.
                if (I_flush) drop_d = 1'b1;
                if (bus.I_arready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.I_rvalid) begin
                    if (drop_q | I_flush) begin
                        drop_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        inst_d  = sel_word;
                        err_d   = (bus.I_rresp != RESP_OKAY);
                        state_d = ST_HOLD;
                    end
                end else if (I_flush) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (I_IF_ID_ready | I_flush) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_REQ;
        endcase
        // dnpc_fire is only possible in HOLD or IDLE, and overrides the exit to IDLE.
        if (dnpc_fire) begin
            pc_d    = I_dnpc;
            state_d = ST_REQ;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end
endmodule
